resp_round_arbiter: RTL



---
 rtl/resp_round_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/resp_round_arbiter.sv
// Round sequencer for a 4-player responder: round-robin first-press arbiter, answer countdown,
// per-player BCD scores and the 6-digit display word. Define RESP_FALSE_START_EN for false-start masking.
module resp_round_arbiter #(
    parameter int TICK_DIV   = 50000000,
    parameter int ANSWER_SEC = 20
) (
    input  logic        s_clk,
    input  logic        s_rst,
    input  logic [3:0]  key_flag,
    input  logic        host_start,
    input  logic        host_ok,
    input  logic        host_clear,
    output logic [3:0]  Led,
    output logic        winner_vld,
    output logic [1:0]  winner_id,
    output logic        busy,
    output logic [23:0] Number_Sig
);
    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_LOCKED, ST_TIMEOUT} state_t;

    localparam int              TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [7:0]      ANS_BCD   = {4'(ANSWER_SEC / 10), 4'(ANSWER_SEC % 10)};

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        if (v == 8'h99) return v;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    state_t          r_state;
    logic [1:0]      r_ptr;
    logic [1:0]      r_winner;
    logic [7:0]      r_cd;
    logic [TW-1:0]   r_tick;
    logic [7:0]      r_score [4];

    state_t          w_nxt_state;
    logic [1:0]      w_nxt_winner;
    logic [7:0]      w_nxt_cd;
    logic            w_score_inc;
    logic            w_tick;
    logic [3:0]      w_keys;
    logic            w_found;
    logic [1:0]      w_pick;
    logic [3:0]      w_armed_led;
    logic [3:0]      w_nxt_led;
    logic [23:0]     w_nxt_num;
    logic            w_nxt_vld;

`ifdef RESP_FALSE_START_EN
    logic [3:0] r_flags;
    logic [3:0] w_flags_nxt;

    assign w_keys      = key_flag & ~r_flags;
    assign w_armed_led = w_flags_nxt;

    // Presses in an uncommanded IDLE cycle arm a penalty that lasts exactly one ARMED period.
    always_comb begin
        w_flags_nxt = r_flags;
        if (r_state == ST_IDLE && !host_clear && !host_ok && !host_start)
            w_flags_nxt = r_flags | key_flag;
        else if (r_state == ST_ARMED && w_nxt_state != ST_ARMED)
            w_flags_nxt = '0;
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) r_flags <= '0;
        else       r_flags <= w_flags_nxt;
    end
`else
    assign w_keys      = key_flag;
    assign w_armed_led = '0;
`endif

    // Search begins at r_ptr, which always holds the index after the previous winner.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        for (int k = 0; k < 4; k++) begin
            if (!w_found && w_keys[r_ptr + 2'(k)]) begin
                w_found = 1'b1;
                w_pick  = r_ptr + 2'(k);
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_winner = r_winner;
        w_nxt_cd     = r_cd;
        w_score_inc  = 1'b0;
        w_tick       = (r_tick == TICK_LAST);
        case (r_state)
            ST_IDLE: begin
                if (!host_clear && !host_ok && host_start) w_nxt_state = ST_ARMED;
            end
            ST_ARMED: begin
                if (host_clear) begin
                    w_nxt_state = ST_IDLE;
                end else if (!host_ok && !host_start && w_found) begin
                    w_nxt_state  = ST_LOCKED;
                    w_nxt_winner = w_pick;
                    w_nxt_cd     = ANS_BCD;
                end
            end
            ST_LOCKED: begin
                if (host_clear) begin
                    w_nxt_state = ST_IDLE;
                end else if (host_ok) begin
                    w_nxt_state = ST_IDLE;
                    w_score_inc = 1'b1;
                end else if (w_tick) begin
                    if (r_cd == 8'h00) w_nxt_state = ST_TIMEOUT;
                    else               w_nxt_cd    = bcd_dec(r_cd);
                end
            end
            ST_TIMEOUT: begin
                if (host_clear)                     w_nxt_state = ST_IDLE;
                else if (!host_ok && host_start)    w_nxt_state = ST_ARMED;
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    // Outputs are computed from next-state values so they register on the same edge as the state.
    always_comb begin
        w_nxt_vld = (w_nxt_state == ST_LOCKED) || (w_nxt_state == ST_TIMEOUT);
        w_nxt_led = '0;
        w_nxt_num = '0;
        if (w_nxt_vld) begin
            w_nxt_led = 4'b0001 << w_nxt_winner;
            w_nxt_num = {{2'b00, w_nxt_winner} + 4'd1, 4'h0, r_score[w_nxt_winner], w_nxt_cd};
        end else if (w_nxt_state == ST_ARMED) begin
            w_nxt_led = w_armed_led;
            w_nxt_num = {16'h0000, ANS_BCD};
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_winner   <= '0;
            r_cd       <= '0;
            r_tick     <= '0;
            // NOTE: the score array is only four registers and must read 00 after reset, so it is reset.
            for (int i = 0; i < 4; i++) r_score[i] <= '0;
            Led        <= '0;
            winner_vld <= 1'b0;
            winner_id  <= '0;
            busy       <= 1'b0;
            Number_Sig <= '0;
        end else begin
            r_state  <= w_nxt_state;
            r_winner <= w_nxt_winner;
            r_cd     <= w_nxt_cd;
            if (r_state == ST_ARMED && w_nxt_state == ST_LOCKED) r_ptr <= w_pick + 2'd1;
            r_tick <= (r_state == ST_LOCKED && w_nxt_state == ST_LOCKED && !w_tick)
                      ? r_tick + 1'b1 : '0;
            if (w_score_inc) r_score[r_winner] <= bcd_inc_sat(r_score[r_winner]);
            Led        <= w_nxt_led;
            winner_vld <= w_nxt_vld;
            winner_id  <= w_nxt_vld ? w_nxt_winner : 2'd0;
            busy       <= (w_nxt_state == ST_ARMED) || (w_nxt_state == ST_LOCKED);
            Number_Sig <= w_nxt_num;
        end
    end
endmodule
